fp_avmm_master: RTL and testbench
=================================

# fp_avmm_master

Avalon-MM initiator that drives the team's 64-bit floating-point operator wrapper from the host side. It accepts one job (two IEEE-754 double operands), writes each operand as two 32-bit byte-enabled beats, and issues a result read. It holds the read through the slave's waitrequest busy window and returns the 64-bit result with an error flag on timeout. It sits between a streaming job source and the operator's Avalon-MM slave port.

## Interface
- `OPA_ADDR`, default 0: word address of operand A.
- `OPB_ADDR`, default 1: word address of operand B.
- `RES_ADDR`, default 1: word address read for the result.
- `TIMEOUT`, default 1024: maximum cycles spent in the read phase before aborting; must be ≥ 2.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `job_valid` in 1: job request.
- `job_ready` out 1: high only in IDLE.
- `op_a` in 64: operand A; sampled on job accept.
- `op_b` in 64: operand B; sampled on job accept.
- `result_valid` out 1: one-cycle pulse when a job completes.
- `result` out 64: result word; held until the next completion.
- `result_err` out 1: set with `result_valid` on timeout; held with `result`.
- `address` out 3: Avalon word address.
- `writedata` out 64: full operand, driven on every write beat.
- `write` out 1: Avalon write.
- `read` out 1: Avalon read.
- `byteenable` out 8: 8'h0F for the low beat, 8'hF0 for the high beat, 8'hFF for the read.
- `readdata` in 64: Avalon read data.
- `waitrequest` in 1: Avalon slave stall/busy.

## Operation
- Accept a job when `job_valid && job_ready` at a clock edge. Latch `op_a` and `op_b` internally; the inputs are don't-care afterwards.
- State sequence: IDLE → WA_L → WA_H → WB_L → WB_H → RD_ARM → RD_WAIT → DONE → IDLE.
- Write states:
  - WA_L: `address=OPA_ADDR`, `writedata=A`, `byteenable=0F`.
  - WA_H: same, but `byteenable=F0`.
  - WB_L / WB_H: the same pair using `OPB_ADDR` and B.
  - `write=1` in all four states.
  - Advance only on an edge with `waitrequest=0`; otherwise hold every output stable.
- Read phase: `read=1`, `address=RES_ADDR`, `byteenable=FF` in RD_ARM and RD_WAIT. The slave completes in two phases:
  - RD_ARM: wait for `waitrequest=1` (computation started), then go to RD_WAIT.
  - RD_WAIT: on the first edge with `waitrequest=0`, capture `readdata` into `result`, clear `result_err`, and go to DONE.
- DONE: `read=0`, `result_valid=1` for exactly one cycle, then IDLE.
- Timeout: an 11-bit-minimum counter (width $clog2(TIMEOUT+1)):
  - Clears on entry to RD_ARM and increments every cycle in RD_ARM or RD_WAIT.
  - On reaching TIMEOUT-1 without completion: go to DONE with `result=0` and `result_err=1`, and drop `read`.
- No job queuing: `job_valid` outside IDLE is ignored.
- Reset mid-operation aborts the transaction immediately:
  - All bus strobes go low and the FSM returns to IDLE.
  - `result` and `result_err` clear and no `result_valid` is issued.
  - The slave is not notified.

## Timing
- Reset values: `job_ready=1` (IDLE); all of the following are 0: `write`, `read`, `address`, `writedata`, `byteenable`, `result_valid`, `result`, `result_err`.
- All outputs are registered or decoded from registered state only; there is no combinational path from `waitrequest` or `readdata` to any output.
- With `waitrequest=0` during writes:
  - Job accepted at edge T → write beats in cycles T+1..T+4 → `read` asserted from T+5.
  - Completion edge E (RD_WAIT, `waitrequest=0`) → `result_valid` high during cycle E+1 → `job_ready` high from E+2.
- Minimum job-to-job period: 8 cycles plus slave busy time.
- If `waitrequest` is already high on the first RD_ARM edge, RD_WAIT is entered the next cycle (one extra cycle).
- A zero-length busy window (`waitrequest` never rises) ends in timeout. This is by design.

## Structure
- Package `fp_avmm_pkg`:
  - State enum.
  - Byteenable constants `BE_LO=8'h0F`, `BE_HI=8'hF0`, `BE_ALL=8'hFF`.
  - Default address constants.
- Sub-module `avmm_rd_timer`: clear/enable/expire counter parameterised by TIMEOUT.
- The FSM and datapath stay in `fp_avmm_master`.

## Test plan
- Operand A 40092AF77DB8CC83, operand B 4018F0329122D34E; slave model busy for 12 cycles, returns 4022C2D727FF9CC8 → four write beats (addr 0,0,1,1; BE 0F,F0,0F,F0), one read, `result=4022C2D727FF9CC8`, `result_err=0`, one-cycle `result_valid`.
- Back-to-back jobs C035A77C30B4E545 + 40846EF84C02BC6E → 4083C1BC6A7D1544, then C0C3330E104E9E8A + BFEBF762613CAAF7 → C0C3337DEDD8237D → `job_ready` low throughout each job; a second `job_valid` held during the first job is accepted only after DONE.
- Slave stalls every write beat for 3 cycles → `address`, `writedata` and `byteenable` stay stable while stalled; exactly 4 beats are accepted.
- TIMEOUT=16 with `waitrequest` never rising → `read` drops after 16 cycles; `result=0`, `result_err=1`, `result_valid` pulses once.
- `reset_n` pulsed low during RD_WAIT → all outputs go to reset values asynchronously; the next job runs normally (405305F0F163539F + C0C376AFB269A3EF → C0C350A3D086DD48).

Source files
------------

// File: rtl/fp_avmm_pkg.sv
// Shared types and constants for the floating-point operator Avalon-MM initiator.
package fp_avmm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WA_L    = 3'd1,
    ST_WA_H    = 3'd2,
    ST_WB_L    = 3'd3,
    ST_WB_H    = 3'd4,
    ST_RD_ARM  = 3'd5,
    ST_RD_WAIT = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  localparam logic [7:0] BE_LO  = 8'h0F;
  localparam logic [7:0] BE_HI  = 8'hF0;
  localparam logic [7:0] BE_ALL = 8'hFF;

  localparam logic [2:0] DEF_OPA_ADDR = 3'd0;
  localparam logic [2:0] DEF_OPB_ADDR = 3'd1;
  localparam logic [2:0] DEF_RES_ADDR = 3'd1;
  localparam int unsigned DEF_TIMEOUT = 1024;

  // Read-phase counter width: enough for TIMEOUT, never narrower than 11 bits.
  function automatic int unsigned timer_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    if (w < 11) begin
      w = 11;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/avmm_rd_timer.sv
// Read-phase watchdog: cleared outside the read phase, counts while enabled,
// flags expiry on the last permitted cycle.
module avmm_rd_timer
  import fp_avmm_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned     CW   = timer_width(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_r;

  // Cycle counter; holds at LAST so it can never wrap back to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != LAST)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = en && (count_r == LAST);

endmodule

// File: rtl/fp_avmm_master.sv
// Avalon-MM initiator: writes two 64-bit operands as byte-enabled half beats,
// then reads the operator result through its busy window with a timeout.
module fp_avmm_master
  import fp_avmm_pkg::*;
#(
  parameter logic [2:0]  OPA_ADDR = DEF_OPA_ADDR,
  parameter logic [2:0]  OPB_ADDR = DEF_OPB_ADDR,
  parameter logic [2:0]  RES_ADDR = DEF_RES_ADDR,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  output logic        result_valid,
  output logic [63:0] result,
  output logic        result_err,
  output logic [2:0]  address,
  output logic [63:0] writedata,
  output logic        write,
  output logic        read,
  output logic [7:0]  byteenable,
  input  logic [63:0] readdata,
  input  logic        waitrequest
);

  state_e      state_r, state_s;
  logic [63:0] op_a_r, op_a_s, op_b_r, op_b_s;
  logic [63:0] result_r, result_s;
  logic        result_err_r, result_err_s;
  logic        rd_phase_s, expired_s, complete_s, timeout_s, accept_s;

  logic        job_ready_r, job_ready_s;
  logic        result_valid_r, result_valid_s;
  logic        write_r, write_s, read_r, read_s;
  logic [2:0]  address_r, address_s;
  logic [63:0] writedata_r, writedata_s;
  logic [7:0]  byteenable_r, byteenable_s;

  assign accept_s   = (state_r == ST_IDLE) && job_valid;
  assign rd_phase_s = (state_r == ST_RD_ARM) || (state_r == ST_RD_WAIT);
  assign complete_s = (state_r == ST_RD_WAIT) && !waitrequest;
  assign timeout_s  = expired_s && !complete_s;

  avmm_rd_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_rd_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!rd_phase_s),
    .en      (rd_phase_s),
    .expired (expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; write beats advance only when the slave is not stalling.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    if (job_valid)    state_s = ST_WA_L;    else state_s = ST_IDLE;
      ST_WA_L:    if (!waitrequest) state_s = ST_WA_H;    else state_s = ST_WA_L;
      ST_WA_H:    if (!waitrequest) state_s = ST_WB_L;    else state_s = ST_WA_H;
      ST_WB_L:    if (!waitrequest) state_s = ST_WB_H;    else state_s = ST_WB_L;
      ST_WB_H:    if (!waitrequest) state_s = ST_RD_ARM;  else state_s = ST_WB_H;
      ST_RD_ARM: begin
        if (expired_s)        state_s = ST_DONE;
        else if (waitrequest) state_s = ST_RD_WAIT;
        else                  state_s = ST_RD_ARM;
      end
      ST_RD_WAIT: if (complete_s || expired_s) state_s = ST_DONE; else state_s = ST_RD_WAIT;
      ST_DONE:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Operand latch and result capture; completion wins over a same-edge expiry.
  always_comb begin
    op_a_s = accept_s ? op_a : op_a_r;
    op_b_s = accept_s ? op_b : op_b_r;
    if (complete_s) begin
      result_s     = readdata;
      result_err_s = 1'b0;
    end else if (timeout_s) begin
      result_s     = 64'd0;
      result_err_s = 1'b1;
    end else begin
      result_s     = result_r;
      result_err_s = result_err_r;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_r       <= 64'd0;
      op_b_r       <= 64'd0;
      result_r     <= 64'd0;
      result_err_r <= 1'b0;
    end else begin
      op_a_r       <= op_a_s;
      op_b_r       <= op_b_s;
      result_r     <= result_s;
      result_err_r <= result_err_s;
    end
  end

  // Output decode of the state being entered, so the registered bus matches the state.
  always_comb begin
    job_ready_s    = 1'b0;
    result_valid_s = 1'b0;
    write_s        = 1'b0;
    read_s         = 1'b0;
    address_s      = 3'd0;
    writedata_s    = 64'd0;
    byteenable_s   = 8'd0;
    case (state_s)
      ST_IDLE: job_ready_s = 1'b1;
      ST_WA_L, ST_WA_H: begin
        write_s      = 1'b1;
        address_s    = OPA_ADDR;
        writedata_s  = op_a_s;
        byteenable_s = (state_s == ST_WA_L) ? BE_LO : BE_HI;
      end
      ST_WB_L, ST_WB_H: begin
        write_s      = 1'b1;
        address_s    = OPB_ADDR;
        writedata_s  = op_b_s;
        byteenable_s = (state_s == ST_WB_L) ? BE_LO : BE_HI;
      end
      ST_RD_ARM, ST_RD_WAIT: begin
        read_s       = 1'b1;
        address_s    = RES_ADDR;
        byteenable_s = BE_ALL;
      end
      ST_DONE: result_valid_s = 1'b1;
      default: job_ready_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      job_ready_r    <= 1'b1;
      result_valid_r <= 1'b0;
      write_r        <= 1'b0;
      read_r         <= 1'b0;
      address_r      <= 3'd0;
      writedata_r    <= 64'd0;
      byteenable_r   <= 8'd0;
    end else begin
      job_ready_r    <= job_ready_s;
      result_valid_r <= result_valid_s;
      write_r        <= write_s;
      read_r         <= read_s;
      address_r      <= address_s;
      writedata_r    <= writedata_s;
      byteenable_r   <= byteenable_s;
    end
  end

  assign job_ready    = job_ready_r;
  assign result_valid = result_valid_r;
  assign result       = result_r;
  assign result_err   = result_err_r;
  assign write        = write_r;
  assign read         = read_r;
  assign address      = address_r;
  assign writedata    = writedata_r;
  assign byteenable   = byteenable_r;

endmodule

// File: tb/tb_fp_avmm_master.sv
// Randomised bench for fp_avmm_master: a behavioural slave plus a per-job
// reference of beats, read duration, latency and result.
module tb_fp_avmm_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        job_valid = 1'b0;
  logic [63:0] op_a = 64'd0;
  logic [63:0] op_b = 64'd0;
  logic [63:0] readdata = 64'd0;
  logic        waitrequest = 1'b0;
  logic        job_ready, result_valid, result_err, write, read;
  logic [63:0] result, writedata;
  logic [2:0]  address;
  logic [7:0]  byteenable;

  fp_avmm_master #(
    .OPA_ADDR (3'd0),
    .OPB_ADDR (3'd1),
    .RES_ADDR (3'd1),
    .TIMEOUT  (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .result_valid (result_valid),
    .result       (result),
    .result_err   (result_err),
    .address      (address),
    .writedata    (writedata),
    .write        (write),
    .read         (read),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .waitrequest  (waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave behaviour knobs for the current job.
  int          cfg_pre = 0, cfg_busy = 0, cfg_stall = 0;
  logic [63:0] cfg_resp = 64'd0;

  typedef struct packed {
    logic [2:0]  addr;
    logic [63:0] data;
    logic [7:0]  be;
  } beat_t;

  beat_t       beats[$];
  int          rd_cnt = 0, stall_cnt = 0;
  int          read_cycles = 0, read_starts = 0, write_cycles = 0;
  logic        prev_read = 1'b0, prev_stalled = 1'b0;
  logic [2:0]  prev_addr = 3'd0;
  logic [63:0] prev_data = 64'd0;
  logic [7:0]  prev_be = 8'd0;

  // Slave model and bus monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    beat_t b;
    if (write) begin
      write_cycles++;
      if (prev_stalled) begin
        check_eq("stall_addr", 64'(address), 64'(prev_addr));
        check_eq("stall_data", writedata, prev_data);
        check_eq("stall_be", 64'(byteenable), 64'(prev_be));
      end
      if (stall_cnt < cfg_stall) begin
        waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        waitrequest = 1'b0;
        stall_cnt = 0;
        b.addr = address;
        b.data = writedata;
        b.be   = byteenable;
        beats.push_back(b);
      end
      prev_stalled = waitrequest;
      prev_addr = address;
      prev_data = writedata;
      prev_be   = byteenable;
      readdata  = {$urandom, $urandom};
    end else if (read) begin
      prev_stalled = 1'b0;
      read_cycles++;
      if (!prev_read) read_starts++;
      if (rd_cnt < cfg_pre) waitrequest = 1'b0;
      else if (rd_cnt < cfg_pre + cfg_busy) waitrequest = 1'b1;
      else waitrequest = 1'b0;
      if (cfg_busy > 0 && rd_cnt >= cfg_pre + cfg_busy) readdata = cfg_resp;
      else readdata = {$urandom, $urandom};
      rd_cnt++;
    end else begin
      waitrequest  = 1'b0;
      rd_cnt       = 0;
      stall_cnt    = 0;
      prev_stalled = 1'b0;
      readdata     = {$urandom, $urandom};
    end
    prev_read = read;
  end

  // One job from acceptance to the cycle after result_valid; called and returns at a negedge.
  task automatic run_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] resp,
                         input int pre, input int busy, input int stall,
                         input bit hold, input logic [63:0] na, input logic [63:0] nb,
                         input string tag);
    bit          tmo, got;
    int          rdc, lat, rdy_seen;
    logic [63:0] exp_res;
    tmo     = (busy == 0) || (pre + busy > TMO - 1);
    rdc     = tmo ? TMO : pre + busy + 1;
    exp_res = tmo ? 64'd0 : resp;
    cfg_pre = pre; cfg_busy = busy; cfg_stall = stall; cfg_resp = resp;
    beats.delete();
    read_cycles = 0; read_starts = 0; write_cycles = 0;
    job_valid = 1'b1; op_a = a; op_b = b;
    check_eq({tag, "_ready_idle"}, 64'(job_ready), 64'd1);
    @(negedge clk);
    if (hold) begin
      op_a = na; op_b = nb;
    end else begin
      job_valid = 1'b0;
      op_a = {$urandom, $urandom};
      op_b = {$urandom, $urandom};
    end
    lat = 1; got = 1'b0; rdy_seen = 0;
    while (!got && lat <= 400) begin
      if (result_valid) begin
        got = 1'b1;
      end else begin
        if (job_ready) rdy_seen++;
        @(negedge clk);
        lat++;
      end
    end
    check_eq({tag, "_valid"}, 64'(got), 64'd1);
    check_eq({tag, "_latency"}, 64'(lat), 64'(4 * (stall + 1) + rdc + 1));
    check_eq({tag, "_ready_busy"}, 64'(rdy_seen), 64'd0);
    check_eq({tag, "_ready_done"}, 64'(job_ready), 64'd0);
    check_eq({tag, "_result"}, result, exp_res);
    check_eq({tag, "_err"}, 64'(result_err), 64'(tmo));
    check_eq({tag, "_nbeats"}, 64'(beats.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < beats.size()) begin
        check_eq({tag, "_beat_addr"}, 64'(beats[i].addr), (i < 2) ? 64'd0 : 64'd1);
        check_eq({tag, "_beat_data"}, beats[i].data, (i < 2) ? a : b);
        check_eq({tag, "_beat_be"}, 64'(beats[i].be), (i % 2 == 0) ? 64'h0F : 64'hF0);
      end
    end
    check_eq({tag, "_wr_cycles"}, 64'(write_cycles), 64'(4 * (stall + 1)));
    check_eq({tag, "_rd_starts"}, 64'(read_starts), 64'd1);
    check_eq({tag, "_rd_cycles"}, 64'(read_cycles), 64'(rdc));
    @(negedge clk);
    check_eq({tag, "_pulse_len"}, 64'(result_valid), 64'd0);
    check_eq({tag, "_ready_after"}, 64'(job_ready), 64'd1);
    check_eq({tag, "_result_held"}, result, exp_res);
    check_eq({tag, "_err_held"}, 64'(result_err), 64'(tmo));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_job_ready"}, 64'(job_ready), 64'd1);
    check_eq({tag, "_write"}, 64'(write), 64'd0);
    check_eq({tag, "_read"}, 64'(read), 64'd0);
    check_eq({tag, "_address"}, 64'(address), 64'd0);
    check_eq({tag, "_writedata"}, writedata, 64'd0);
    check_eq({tag, "_byteenable"}, 64'(byteenable), 64'd0);
    check_eq({tag, "_result_valid"}, 64'(result_valid), 64'd0);
    check_eq({tag, "_result"}, result, 64'd0);
    check_eq({tag, "_result_err"}, 64'(result_err), 64'd0);
  endtask

  // Asynchronous reset while the read is stalled in the busy window.
  task automatic reset_mid_job();
    cfg_pre = 1; cfg_busy = 12; cfg_stall = 0; cfg_resp = {$urandom, $urandom};
    job_valid = 1'b1; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    @(negedge clk);
    job_valid = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("rst_pre_read", 64'(read), 64'd1);
    check_eq("rst_pre_busy", 64'(waitrequest), 64'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("rst_async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("rst_no_valid", 64'(result_valid), 64'd0);
      check_eq("rst_no_read", 64'(read), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] ra, rb, rr;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_job(64'h40092AF77DB8CC83, 64'h4018F0329122D34E, 64'h4022C2D727FF9CC8,
            1, 12, 0, 1'b0, 64'd0, 64'd0, "basic");
    run_job(64'hC035A77C30B4E545, 64'h40846EF84C02BC6E, 64'h4083C1BC6A7D1544,
            2, 5, 0, 1'b1, 64'hC0C3330E104E9E8A, 64'hBFEBF762613CAAF7, "b2b_1");
    run_job(64'hC0C3330E104E9E8A, 64'hBFEBF762613CAAF7, 64'hC0C3337DEDD8237D,
            0, 7, 0, 1'b0, 64'd0, 64'd0, "b2b_2");
    run_job({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            1, 4, 3, 1'b0, 64'd0, 64'd0, "stall");
    run_job({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            1, 0, 1, 1'b0, 64'd0, 64'd0, "timeout");
    run_job({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            3, 12, 0, 1'b0, 64'd0, 64'd0, "edge_last");
    reset_mid_job();
    run_job(64'h405305F0F163539F, 64'hC0C376AFB269A3EF, 64'hC0C350A3D086DD48,
            1, 3, 0, 1'b0, 64'd0, 64'd0, "post_rst");
    for (int i = 0; i < 12; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rr = {$urandom, $urandom};
      run_job(ra, rb, rr, int'($urandom_range(0, 3)), int'($urandom_range(0, 14)),
              int'($urandom_range(0, 2)), 1'b0, 64'd0, 64'd0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
